// File: rtl/reg_renamer_ckpt.sv
`default_nettype none
// reg_renamer_ckpt: physical-register free list with all-or-nothing multi-lane allocation,
// multi-lane frees and one-cycle checkpoint restore.  Rev 1.0
module reg_renamer_ckpt #(
  parameter int PREG   = 128,
  parameter int TAGW   = $clog2(PREG),
  parameter int NALLOC = 4,
  parameter int NFREE  = 20,
  parameter int NCKPT  = 4,
  parameter int CKW    = $clog2(NCKPT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NALLOC-1:0]             alloc_req,
  output logic                          stall,
  output logic [NALLOC-1:0][TAGW-1:0]   wo,
  output logic [NALLOC-1:0]             wv,
  input  logic [NFREE-1:0][TAGW-1:0]    tags2free,
  input  logic [NFREE-1:0]              freevals,
  input  logic                          ckpt_save,
  input  logic [CKW-1:0]                ckpt_wid,
  input  logic                          ckpt_restore,
  input  logic [CKW-1:0]                ckpt_rid,
  output logic [TAGW:0]                 free_cnt,
  output logic                          dbl_free
);

  localparam logic [PREG-1:0] RST_AVAIL = {{(PREG-1){1'b1}}, 1'b0};

  logic [PREG-1:0]              avail;
  logic [PREG-1:0]              ckpt [NCKPT];
  logic [PREG-1:0]              freeset;
  logic [PREG-1:0]              alloc_mask;
  logic [PREG-1:0]              avail_nxt;
  logic [NALLOC-1:0][TAGW-1:0]  alloc_tag;
  logic [TAGW:0]                n_req;
  logic [TAGW:0]                cnt_nxt;
  logic                         dbl_hit;
  logic                         grant;
  logic                         found;

  // Frees: tag 0 and out-of-range tags are ignored; duplicates simply re-set the same bit.
  always_comb begin
    freeset = '0;
    dbl_hit = 1'b0;
    for (int k = 0; k < NFREE; k++) begin
      if (freevals[k] && (tags2free[k] != '0) && (int'(tags2free[k]) < PREG)) begin
        freeset[tags2free[k]] = 1'b1;
        if (avail[tags2free[k]]) dbl_hit = 1'b1;
      end
    end
  end

  // Each requesting lane, in lane order, claims the lowest free tag left by earlier lanes.
  always_comb begin
    alloc_mask = avail;
    alloc_tag  = '0;
    found      = 1'b0;
    for (int i = 0; i < NALLOC; i++) begin
      found = 1'b0;
      if (alloc_req[i]) begin
        for (int j = 0; j < PREG; j++) begin
          if (!found && alloc_mask[j]) begin
            found         = 1'b1;
            alloc_tag[i]  = TAGW'(j);
            alloc_mask[j] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    n_req = '0;
    for (int i = 0; i < NALLOC; i++) n_req = n_req + (TAGW+1)'(alloc_req[i]);
  end

  assign stall = ckpt_restore | (n_req > free_cnt);
  assign grant = !stall && (n_req != '0);

  always_comb begin
    if (ckpt_restore)
      avail_nxt = ckpt[ckpt_rid] | freeset;
    else if (grant)
      avail_nxt = alloc_mask | freeset;
    else
      avail_nxt = avail | freeset;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int j = 0; j < PREG; j++) cnt_nxt = cnt_nxt + (TAGW+1)'(avail_nxt[j]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail    <= RST_AVAIL;
      wo       <= '0;
      wv       <= '0;
      free_cnt <= (TAGW+1)'(PREG-1);
      dbl_free <= 1'b0;
    end else begin
      avail    <= avail_nxt;
      free_cnt <= cnt_nxt;
      wv       <= grant ? alloc_req : '0;
      if (dbl_hit) dbl_free <= 1'b1;
      for (int i = 0; i < NALLOC; i++) begin
        if (grant && alloc_req[i]) wo[i] <= alloc_tag[i];
      end
    end
  end

  // Every slot absorbs this cycle's frees so commits after a snapshot survive a restore.
  generate
    for (genvar s = 0; s < NCKPT; s++) begin : g_ckpt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ckpt[s] <= RST_AVAIL;
        else if (ckpt_save && !ckpt_restore && (ckpt_wid == CKW'(s)))
          ckpt[s] <= avail_nxt;
        else
          ckpt[s] <= ckpt[s] | freeset;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_renamer_ckpt.sv
`default_nettype none
// tb_reg_renamer_ckpt: directed self-checking bench for reg_renamer_ckpt.  Rev 1.0
module tb_reg_renamer_ckpt;

  localparam int PREG   = 128;
  localparam int TAGW   = 7;
  localparam int NALLOC = 4;
  localparam int NFREE  = 20;
  localparam int CKW    = 2;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NALLOC-1:0]            alloc_req;
  logic                         stall;
  logic [NALLOC-1:0][TAGW-1:0]  wo;
  logic [NALLOC-1:0]            wv;
  logic [NFREE-1:0][TAGW-1:0]   tags2free;
  logic [NFREE-1:0]             freevals;
  logic                         ckpt_save;
  logic [CKW-1:0]               ckpt_wid;
  logic                         ckpt_restore;
  logic [CKW-1:0]               ckpt_rid;
  logic [TAGW:0]                free_cnt;
  logic                         dbl_free;

  int passed = 0;
  int total  = 0;

  reg_renamer_ckpt #(.PREG(PREG), .NALLOC(NALLOC), .NFREE(NFREE), .NCKPT(4)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .stall(stall), .wo(wo), .wv(wv),
    .tags2free(tags2free), .freevals(freevals), .ckpt_save(ckpt_save), .ckpt_wid(ckpt_wid),
    .ckpt_restore(ckpt_restore), .ckpt_rid(ckpt_rid), .free_cnt(free_cnt), .dbl_free(dbl_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req    = '0;
    freevals     = '0;
    tags2free    = '0;
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
    ckpt_wid     = '0;
    ckpt_rid     = '0;
  endtask

  task automatic free1(input int lane, input int tag);
    freevals[lane]  = 1'b1;
    tags2free[lane] = TAGW'(tag);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_free_cnt", 32'(free_cnt), 127);
    chk("rst_wv", 32'(wv), 0);
    chk("rst_wo", 32'(wo), 0);
    chk("rst_dbl", 32'(dbl_free), 0);
    chk("rst_stall", 32'(stall), 0);
    tick();
    rst_n = 1'b1;

    // Four-lane grant
    alloc_req = 4'b1111;
    #1 chk("t1_stall", 32'(stall), 0);
    tick();
    chk("t1_wo0", 32'(wo[0]), 1);
    chk("t1_wo1", 32'(wo[1]), 2);
    chk("t1_wo2", 32'(wo[2]), 3);
    chk("t1_wo3", 32'(wo[3]), 4);
    chk("t1_wv", 32'(wv), 4'b1111);
    chk("t1_cnt", 32'(free_cnt), 123);

    // Sparse lanes
    alloc_req = 4'b1010;
    tick();
    chk("t2_wo0", 32'(wo[0]), 1);
    chk("t2_wo1", 32'(wo[1]), 5);
    chk("t2_wo2", 32'(wo[2]), 3);
    chk("t2_wo3", 32'(wo[3]), 6);
    chk("t2_wv", 32'(wv), 4'b1010);
    chk("t2_cnt", 32'(free_cnt), 121);
    idle();
    tick();
    chk("t2_wv_idle", 32'(wv), 0);

    // Drain to two free tags (126, 127)
    alloc_req = 4'b1111;
    for (int c = 0; c < 29; c++) tick();
    alloc_req = 4'b0111;
    tick();
    chk("t3_wo2_last", 32'(wo[2]), 125);
    chk("t3_cnt2", 32'(free_cnt), 2);
    #1 chk("t3_stall", 32'(stall), 1);
    tick();
    chk("t3_wv_stall", 32'(wv), 0);
    chk("t3_cnt_hold", 32'(free_cnt), 2);
    free1(0, 7);
    free1(3, 9);
    #1 chk("t3_stall_free", 32'(stall), 1);
    tick();
    chk("t3_cnt4", 32'(free_cnt), 4);
    chk("t3_wv_free", 32'(wv), 0);
    freevals = '0;
    #1 chk("t3_nostall", 32'(stall), 0);
    tick();
    chk("t3_wo0", 32'(wo[0]), 7);
    chk("t3_wo1", 32'(wo[1]), 9);
    chk("t3_wo2", 32'(wo[2]), 126);
    chk("t3_wv", 32'(wv), 4'b0111);
    chk("t3_cnt1", 32'(free_cnt), 1);
    alloc_req = 4'b0001;
    #1 chk("t3_exact_nostall", 32'(stall), 0);
    tick();
    chk("t3_exact_wo0", 32'(wo[0]), 127);
    chk("t3_cnt0", 32'(free_cnt), 0);
    #1 chk("t3_empty_stall", 32'(stall), 1);
    tick();
    chk("t3_empty_wv", 32'(wv), 0);

    // Checkpoint save / restore
    idle();
    pulse_reset();
    chk("t4_rst_cnt", 32'(free_cnt), 127);
    alloc_req = 4'b1111;
    for (int c = 0; c < 6; c++) tick();
    alloc_req = 4'b0111;
    tick();
    chk("t4_cnt100", 32'(free_cnt), 100);
    alloc_req = '0;
    ckpt_save = 1'b1;
    ckpt_wid  = 2'd2;
    tick();
    ckpt_save = 1'b0;
    alloc_req = 4'b1111;
    tick();
    tick();
    chk("t4_wo3_post", 32'(wo[3]), 35);
    chk("t4_cnt92", 32'(free_cnt), 92);
    alloc_req = '0;
    free1(0, 3);
    tick();
    chk("t4_cnt93", 32'(free_cnt), 93);
    freevals     = '0;
    alloc_req    = 4'b1111;
    ckpt_restore = 1'b1;
    ckpt_rid     = 2'd2;
    #1 chk("t4_restore_stall", 32'(stall), 1);
    tick();
    chk("t4_restore_wv", 32'(wv), 0);
    chk("t4_cnt101", 32'(free_cnt), 101);
    ckpt_restore = 1'b0;
    tick();
    chk("t4_wo0", 32'(wo[0]), 3);
    chk("t4_wo1", 32'(wo[1]), 28);
    chk("t4_wo3", 32'(wo[3]), 30);
    chk("t4_cnt97", 32'(free_cnt), 97);

    // Save and restore together
    alloc_req    = '0;
    ckpt_save    = 1'b1;
    ckpt_wid     = 2'd2;
    ckpt_restore = 1'b1;
    ckpt_rid     = 2'd2;
    free1(2, 10);
    tick();
    chk("t5_cnt102", 32'(free_cnt), 102);
    idle();
    alloc_req = 4'b1111;
    tick();
    chk("t5_wo1", 32'(wo[1]), 10);
    chk("t5_cnt98", 32'(free_cnt), 98);
    alloc_req    = '0;
    ckpt_save    = 1'b1;
    ckpt_wid     = 2'd1;
    ckpt_restore = 1'b1;
    ckpt_rid     = 2'd2;
    tick();
    chk("t5_restore2_cnt", 32'(free_cnt), 102);
    ckpt_save    = 1'b0;
    ckpt_rid     = 2'd1;
    tick();
    chk("t5_slot1_intact", 32'(free_cnt), 127);
    chk("t5_dbl_clear", 32'(dbl_free), 0);

    // Duplicate frees, tag 0, double free
    idle();
    alloc_req = 4'b1111;
    tick();
    chk("t6_cnt123", 32'(free_cnt), 123);
    alloc_req = '0;
    free1(0, 2);
    free1(5, 2);
    free1(1, 0);
    tick();
    chk("t6_dup_cnt", 32'(free_cnt), 124);
    chk("t6_dup_dbl", 32'(dbl_free), 0);
    freevals = '0;
    free1(7, 50);
    tick();
    chk("t6_dbl_set", 32'(dbl_free), 1);
    chk("t6_dbl_cnt", 32'(free_cnt), 124);
    freevals = '0;
    tick();
    chk("t6_dbl_sticky", 32'(dbl_free), 1);

    // Asynchronous reset between edges
    alloc_req = 4'b1111;
    tick();
    chk("t6_pre_rst_wv", 32'(wv), 4'b1111);
    chk("t6_pre_rst_wo0", 32'(wo[0]), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_arst_wv", 32'(wv), 0);
    chk("t6_arst_wo", 32'(wo), 0);
    chk("t6_arst_cnt", 32'(free_cnt), 127);
    chk("t6_arst_dbl", 32'(dbl_free), 0);
    rst_n = 1'b1;
    idle();
    tick();
    chk("t6_post_rst_cnt", 32'(free_cnt), 127);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
